// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl_if
// Description : Client-side request/response bundle for sram_ctrl.
//               The master is the ring-buffer client. The slave is the
//               controller.
//   i_req    client request strobe
//   i_we     1 = write, 0 = read (sampled with i_req)
//   i_addr   20-bit word address (sampled with i_req)
//   i_wdata  16-bit write data (sampled with i_req)
//   o_ready  controller idle; a request is accepted when i_req && o_ready
//   o_rdata  last word read, held until the next read completes
//   o_rvalid one-cycle pulse when o_rdata updates
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_ctrl_if;
  logic        i_req;
  logic        i_we;
  logic [19:0] i_addr;
  logic [15:0] i_wdata;
  logic        o_ready;
  logic [15:0] o_rdata;
  logic        o_rvalid;

  modport master (
    output i_req, i_we, i_addr, i_wdata,
    input  o_ready, o_rdata, o_rvalid
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata,
    output o_ready, o_rdata, o_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : Sequences single-word client reads and writes onto an
//               asynchronous 1M x 16 SRAM. Write cycles use separate
//               setup, WE_N strobe and hold phases. Read cycles hold OE_N
//               low for a wait period before sampling DQ. An idle
//               turnaround cycle always separates two transactions.
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   bus          client request/response bundle (slave side)
//   o_SRAM_ADDR  SRAM word address, loaded on request accept
//   io_SRAM_DQ   bidirectional SRAM data bus, driven only in write states
//   o_SRAM_WE_N  write strobe (active low)
//   o_SRAM_OE_N  output enable (active low)
//   o_SRAM_CE_N  chip enable (active low, permanently asserted)
//   o_SRAM_LB_N  lower byte enable (active low, permanently asserted)
//   o_SRAM_UB_N  upper byte enable (active low, permanently asserted)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
  parameter int WR_PULSE_CYCLES = 1,  // legal 1..7
  parameter int RD_WAIT_CYCLES  = 1   // legal 1..7
) (
  input  wire logic        i_clk,
  input  wire logic        i_rst_n,
  sram_ctrl_if.slave       bus,
  output logic [19:0]      o_SRAM_ADDR,
  inout  wire logic [15:0] io_SRAM_DQ,
  output logic             o_SRAM_WE_N,
  output logic             o_SRAM_OE_N,
  output logic             o_SRAM_CE_N,
  output logic             o_SRAM_LB_N,
  output logic             o_SRAM_UB_N
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_SETUP  = 3'd1,
    S_WR_PULSE  = 3'd2,
    S_WR_HOLD   = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_RD_SAMPLE = 3'd5
  } state_t;

  // The down-counters are loaded with N-1 so that a phase lasts N cycles.
  localparam logic [2:0] c_WR_LOAD = 3'(WR_PULSE_CYCLES - 1);
  localparam logic [2:0] c_RD_LOAD = 3'(RD_WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_accept;

  logic [19:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_rvalid;
  logic        r_we_n;
  logic        r_oe_n;
  logic        r_dq_oe;

  assign w_accept = (r_state == S_IDLE) && bus.i_req;

  // Next-state and phase-counter decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.i_req) begin
          if (bus.i_we) begin
            w_state_nxt = S_WR_SETUP;
          end else begin
            w_state_nxt = S_RD_WAIT;
            w_cnt_nxt   = c_RD_LOAD;
          end
        end
      end
      S_WR_SETUP: begin
        w_state_nxt = S_WR_PULSE;
        w_cnt_nxt   = c_WR_LOAD;
      end
      S_WR_PULSE: begin
        if (r_cnt == 3'd0) w_state_nxt = S_WR_HOLD;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_WR_HOLD:   w_state_nxt = S_IDLE;
      S_RD_WAIT: begin
        if (r_cnt == 3'd0) w_state_nxt = S_RD_SAMPLE;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      S_RD_SAMPLE: w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Pin registers are loaded from the next-state decode so that the pin
  // levels belong to the state that is entered at this edge. The
  // asynchronous reset releases WE_N and the DQ drive immediately, which
  // aborts a write that is in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_addr   <= 20'd0;
      r_wdata  <= 16'd0;
      r_rdata  <= 16'd0;
      r_rvalid <= 1'b0;
      r_we_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_dq_oe  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_we_n   <= (w_state_nxt != S_WR_PULSE);
      r_oe_n   <= !((w_state_nxt == S_RD_WAIT) || (w_state_nxt == S_RD_SAMPLE));
      r_dq_oe  <= (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                  (w_state_nxt == S_WR_HOLD);
      if (w_accept) begin
        r_addr  <= bus.i_addr;
        r_wdata <= bus.i_wdata;
      end
      // DQ is captured at the end of the sample cycle while OE_N is still
      // low. rvalid therefore lines up with the first idle cycle.
      r_rvalid <= (r_state == S_RD_SAMPLE);
      if (r_state == S_RD_SAMPLE) r_rdata <= io_SRAM_DQ;
    end
  end

  assign io_SRAM_DQ   = r_dq_oe ? r_wdata : 16'hzzzz;

  assign bus.o_ready  = (r_state == S_IDLE);
  assign bus.o_rdata  = r_rdata;
  assign bus.o_rvalid = r_rvalid;

  assign o_SRAM_ADDR  = r_addr;
  assign o_SRAM_WE_N  = r_we_n;
  assign o_SRAM_OE_N  = r_oe_n;
  // The chip is always selected and both byte lanes are always enabled.
  // Partial-word writes are not supported.
  assign o_SRAM_CE_N  = 1'b0;
  assign o_SRAM_LB_N  = 1'b0;
  assign o_SRAM_UB_N  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Directed self-checking bench for sram_ctrl. Two instances
//               are built: one with default timing and one with
//               WR_PULSE_CYCLES=3 and RD_WAIT_CYCLES=2. Each DQ bus has a
//               pull-up, so an undriven bus reads back as 16'hFFFF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sram_ctrl_if bus0 ();
  sram_ctrl_if bus1 ();

  wire  [15:0] dq0;
  wire  [15:0] dq1;
  logic [19:0] addr0, addr1;
  logic        we_n0, oe_n0, ce_n0, lb_n0, ub_n0;
  logic        we_n1, oe_n1, ce_n1, lb_n1, ub_n1;

  sram_ctrl dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave),
    .o_SRAM_ADDR(addr0), .io_SRAM_DQ(dq0), .o_SRAM_WE_N(we_n0),
    .o_SRAM_OE_N(oe_n0), .o_SRAM_CE_N(ce_n0), .o_SRAM_LB_N(lb_n0),
    .o_SRAM_UB_N(ub_n0)
  );

  sram_ctrl #(.WR_PULSE_CYCLES(3), .RD_WAIT_CYCLES(2)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave),
    .o_SRAM_ADDR(addr1), .io_SRAM_DQ(dq1), .o_SRAM_WE_N(we_n1),
    .o_SRAM_OE_N(oe_n1), .o_SRAM_CE_N(ce_n1), .o_SRAM_LB_N(lb_n1),
    .o_SRAM_UB_N(ub_n1)
  );

  for (genvar gi = 0; gi < 16; gi++) begin : g_pull
    pullup (dq0[gi]);
    pullup (dq1[gi]);
  end

  // Small SRAM models, indexed by the low address nibble
  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  always @(posedge clk) if (!we_n0 && !ce_n0) mem0[addr0[3:0]] <= dq0;
  always @(posedge clk) if (!we_n1 && !ce_n1) mem1[addr1[3:0]] <= dq1;
  assign dq0 = (!oe_n0 && we_n0 && !ce_n0) ? mem0[addr0[3:0]] : 16'hzzzz;
  assign dq1 = (!oe_n1 && we_n1 && !ce_n1) ? mem1[addr1[3:0]] : 16'hzzzz;

  // Per-cycle activity counters and bus-conflict monitor
  int we_lo0 = 0, oe_lo0 = 0, rv0 = 0, we_lo1 = 0, oe_lo1 = 0, rv1 = 0, ovl = 0;
  always @(negedge clk) begin
    if (!we_n0) we_lo0++;
    if (!oe_n0) oe_lo0++;
    if (bus0.o_rvalid) rv0++;
    if (!we_n1) we_lo1++;
    if (!oe_n1) oe_lo1++;
    if (bus1.o_rvalid) rv1++;
    if (!oe_n0 && (!we_n0 || dq0 !== mem0[addr0[3:0]])) ovl++;
    if (!oe_n1 && (!we_n1 || dq1 !== mem1[addr1[3:0]])) ovl++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on dut1. lat is the number of edges from the accept
  // edge until ready is seen again. It is bounded at 20.
  task automatic xact1(input logic we, input logic [19:0] a, input logic [15:0] d,
                       output int lat);
    bus1.i_req = 1'b1; bus1.i_we = we; bus1.i_addr = a; bus1.i_wdata = d;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus1.i_req = 1'b0;
    while (!bus1.o_ready && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, s_we, s_oe, s_rv;
    logic [6:0] p_rdy, p_we, p_oe, p_rv;

    bus0.i_req = 1'b0; bus0.i_we = 1'b0; bus0.i_addr = '0; bus0.i_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_we = 1'b0; bus1.i_addr = '0; bus1.i_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Reset / idle state
    chk("rst_we_n", we_n0, 1);
    chk("rst_oe_n", oe_n0, 1);
    chk("rst_dq_hiz", dq0, 16'hFFFF);
    chk("rst_ready", bus0.o_ready, 1);
    chk("rst_rvalid", bus0.o_rvalid, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_rdata", bus0.o_rdata, 0);
    chk("rst_ce_lb_ub", {ce_n0, lb_n0, ub_n0}, 0);

    // Default-timing write
    bus0.i_req = 1'b1; bus0.i_we = 1'b1; bus0.i_addr = 20'h00010; bus0.i_wdata = 16'hA5C3;
    @(negedge clk); bus0.i_req = 1'b0;
    chk("wr_setup_we_n", we_n0, 1);
    chk("wr_setup_dq", dq0, 16'hA5C3);
    chk("wr_setup_ready", bus0.o_ready, 0);
    chk("wr_addr", addr0, 20'h00010);
    @(negedge clk);
    chk("wr_pulse_we_n", we_n0, 0);
    chk("wr_pulse_dq", dq0, 16'hA5C3);
    @(negedge clk);
    chk("wr_hold_we_n", we_n0, 1);
    chk("wr_hold_dq", dq0, 16'hA5C3);
    chk("wr_hold_ready", bus0.o_ready, 0);
    @(negedge clk);
    chk("wr_done_ready", bus0.o_ready, 1);
    chk("wr_done_dq_hiz", dq0, 16'hFFFF);

    // Default-timing read
    bus0.i_req = 1'b1; bus0.i_we = 1'b0; bus0.i_addr = 20'h00010; bus0.i_wdata = 16'h0000;
    @(negedge clk); bus0.i_req = 1'b0;
    chk("rd_wait_oe_n", oe_n0, 0);
    chk("rd_wait_dq", dq0, 16'hA5C3);
    chk("rd_wait_rvalid", bus0.o_rvalid, 0);
    @(negedge clk);
    chk("rd_sample_oe_n", oe_n0, 0);
    chk("rd_sample_ready", bus0.o_ready, 0);
    @(negedge clk);
    chk("rd_done_ready", bus0.o_ready, 1);
    chk("rd_done_rvalid", bus0.o_rvalid, 1);
    chk("rd_done_rdata", bus0.o_rdata, 16'hA5C3);
    chk("rd_done_oe_n", oe_n0, 1);
    @(negedge clk);
    chk("rd_after_rvalid", bus0.o_rvalid, 0);
    chk("rd_after_rdata_hold", bus0.o_rdata, 16'hA5C3);

    // Back-to-back write (top address) then read, with i_req held high
    bus0.i_req = 1'b1; bus0.i_we = 1'b1; bus0.i_addr = 20'hFFFFF; bus0.i_wdata = 16'h5A3C;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) begin bus0.i_we = 1'b0; bus0.i_addr = 20'h00010; bus0.i_wdata = 16'h0000; end
      if (k == 4) bus0.i_req = 1'b0;
      if (k == 2) chk("b2b_wr_addr", addr0, 20'hFFFFF);
      if (k == 4) chk("b2b_rd_addr", addr0, 20'h00010);
      p_rdy[k] = bus0.o_ready; p_we[k] = we_n0; p_oe[k] = oe_n0; p_rv[k] = bus0.o_rvalid;
    end
    chk("b2b_ready_pat", p_rdy, 7'b1001000);
    chk("b2b_we_n_pat", p_we, 7'b1111101);
    chk("b2b_oe_n_pat", p_oe, 7'b1001111);
    chk("b2b_rvalid_pat", p_rv, 7'b1000000);
    chk("b2b_rdata", bus0.o_rdata, 16'hA5C3);

    // Read back the top address
    bus0.i_req = 1'b1; bus0.i_we = 1'b0; bus0.i_addr = 20'hFFFFF;
    @(negedge clk); bus0.i_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("top_addr_rvalid", bus0.o_rvalid, 1);
    chk("top_addr_rdata", bus0.o_rdata, 16'h5A3C);

    // Slow-timing instance
    s_we = we_lo1; s_oe = oe_lo1; s_rv = rv1;
    xact1(1'b1, 20'h00003, 16'hBEEF, lat);
    @(negedge clk);
    chk("slow_wr_latency", lat, 5);
    chk("slow_we_low_cycles", we_lo1 - s_we, 3);
    xact1(1'b0, 20'h00003, 16'h0000, lat);
    chk("slow_rd_rvalid", bus1.o_rvalid, 1);
    @(negedge clk);
    chk("slow_rd_latency", lat, 3);
    chk("slow_oe_low_cycles", oe_lo1 - s_oe, 3);
    chk("slow_rd_rdata", bus1.o_rdata, 16'hBEEF);
    chk("slow_rvalid_count", rv1 - s_rv, 1);

    // Reset in the middle of a write strobe
    s_rv = rv0;
    bus0.i_req = 1'b1; bus0.i_we = 1'b1; bus0.i_addr = 20'h00005; bus0.i_wdata = 16'h0F0F;
    @(negedge clk); bus0.i_req = 1'b0;
    @(negedge clk);
    chk("abort_pulse_we_n", we_n0, 0);
    chk("abort_pulse_dq", dq0, 16'h0F0F);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_we_n", we_n0, 1);
    chk("abort_wr_dq_hiz", dq0, 16'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("abort_wr_ready", bus0.o_ready, 1);
    chk("abort_wr_rvalid", bus0.o_rvalid, 0);

    // Reset in the middle of a read sample
    bus0.i_req = 1'b1; bus0.i_we = 1'b0; bus0.i_addr = 20'h00010;
    @(negedge clk); bus0.i_req = 1'b0;
    @(negedge clk);
    chk("abort_rd_pre_oe_n", oe_n0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd_oe_n", oe_n0, 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_rd_ready", bus0.o_ready, 1);
    chk("abort_rd_rdata", bus0.o_rdata, 0);
    chk("abort_no_rvalid", rv0 - s_rv, 0);

    chk("no_bus_overlap", ovl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Sits directly downstream of the colour-delay ring buffer, between its SRAM-side client port (write enable, address, write data, read data) and the DE2-115 off-chip 1M x 16 SRAM pins.
Turns single-word read/write requests into correctly sequenced SRAM cycles:
- separate setup, strobe and hold phases;
- tristate control of the bidirectional DQ bus;
- a guaranteed idle turnaround cycle between transactions.
One request in flight at a time.

Parameters:
WR_PULSE_CYCLES, 1, number of cycles WE_N is held low per write (legal 1..7)
RD_WAIT_CYCLES, 1, number of cycles OE_N is low before DQ is sampled (legal 1..7)

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_req  input  1  client request strobe
i_we  input  1  1 = write, 0 = read; sampled with i_req
i_addr  input  20  word address; sampled with i_req
i_wdata  input  16  write data; sampled with i_req
o_ready  output  1  high only in S_IDLE; request accepted on edge where i_req && o_ready
o_rdata  output  16  last read word; holds until next read completes
o_rvalid  output  1  one-cycle pulse when o_rdata updates
o_SRAM_ADDR  output  20  SRAM address
io_SRAM_DQ  inout  16  SRAM data bus
o_SRAM_WE_N  output  1  write strobe, active low
o_SRAM_OE_N  output  1  output enable, active low
o_SRAM_CE_N  output  1  chip enable, active low
o_SRAM_LB_N  output  1  lower byte enable, active low
o_SRAM_UB_N  output  1  upper byte enable, active low

Behaviour:
- All outputs are registered except o_ready, which decodes the state register.
- Reset values:
  - state S_IDLE, o_rdata 0, o_rvalid 0, o_SRAM_ADDR 0;
  - WE_N 1, OE_N 1, CE_N 0, LB_N 0, UB_N 0;
  - DQ drive disabled (high-Z).
- Reset asserted mid-transaction aborts immediately:
  - WE_N deasserts asynchronously;
  - DQ goes high-Z;
  - no o_rvalid is produced.
- Accept (S_IDLE, i_req=1):
  - latch i_addr into o_SRAM_ADDR and i_wdata into the internal write register;
  - branch on i_we.
- i_req while not ready is ignored, not queued. The client must hold or re-issue the request.
- State machine:
  - S_IDLE -> S_WR_SETUP on accept with i_we=1; -> S_RD_WAIT on accept with i_we=0; else stay.
  - S_WR_SETUP (1 cycle): DQ driven with write data, WE_N=1. -> S_WR_PULSE.
  - S_WR_PULSE (WR_PULSE_CYCLES cycles, down-counter): DQ driven, WE_N=0. -> S_WR_HOLD.
  - S_WR_HOLD (1 cycle): DQ driven, WE_N=1. -> S_IDLE.
  - S_RD_WAIT (RD_WAIT_CYCLES cycles): DQ high-Z, OE_N=0. -> S_RD_SAMPLE.
  - S_RD_SAMPLE (1 cycle): OE_N=0; at the end of this cycle DQ is captured into o_rdata and o_rvalid=1 for the following cycle. -> S_IDLE.
- Output registers are loaded from next-state decode, so pin levels match the state named above during that state.
- Latency from accept edge to o_ready high again:
  - write: WR_PULSE_CYCLES + 2 cycles (default 3);
  - read: RD_WAIT_CYCLES + 1 cycles (default 2).
- o_rvalid coincides with the first S_IDLE cycle after a read.
- Bus safety:
  - DQ is driven only in write states;
  - OE_N=0 only in read states;
  - DQ drive and OE_N=0 are never active in the same cycle;
  - S_IDLE always lasts at least one cycle between transactions, which gives one turnaround cycle.
- o_SRAM_ADDR is stable from the setup/wait state through S_IDLE; it changes only on accept.
- Address 0xFFFFF and address 0 need no special handling (no wrap logic here). Ring-buffer wrap is the client's job.
- Byte enables are always both active; no partial writes.

Test Plan:
- Reset, idle 5 cycles -> WE_N=1, OE_N=1, DQ high-Z, o_ready=1, o_rvalid=0.
- Write addr 0x00010 data 0xA5C3 (defaults) -> one setup cycle, WE_N low exactly 1 cycle, one hold cycle; DQ=0xA5C3 for all 3 cycles; o_ready back 3 cycles after accept.
- Read addr 0x00010 with SRAM model returning 0xA5C3 -> OE_N low 2 cycles; o_rvalid pulses once 2 cycles after accept; o_rdata=0xA5C3 and holds after the pulse.
- Back-to-back write then read, i_req held high -> exactly one S_IDLE cycle in between; bench asserts DQ drive and OE_N low never overlap.
- WR_PULSE_CYCLES=3, RD_WAIT_CYCLES=2 -> WE_N low 3 cycles; read latency 3 cycles; write latency 5 cycles.
- Assert i_rst_n low during S_WR_PULSE -> WE_N=1 and DQ high-Z before the next clock; after release, o_ready=1 and no o_rvalid.
